// File: rtl/ola_pkg.sv
// ola_pkg: shared types and helpers for the online adder array.
//   state_t       frame controller states
//   ONLINE_DELAY  input digits consumed before the first result digit
//   DIG_*         borrow-save digit encodings {plus, minus}
//   full_add      returns {carry, sum} of three bits
package ola_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int ONLINE_DELAY = 2;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/ola_digit_slice.sv
// ola_digit_slice: one channel of the radix-2 borrow-save online adder.
// Two full-adder levels, registered between them and at the output.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   adv                 advance strobe; all registers hold when low
//   clr                 first advance of a frame: previous stage state
//                       is taken as zero so frames never interact
//   x_plus/x_minus      borrow-save digit of X
//   y_plus/y_minus      borrow-save digit of Y
//   z_plus/z_minus      borrow-save result digit
module ola_digit_slice
  import ola_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  input  logic clr,
  input  logic x_plus,
  input  logic x_minus,
  input  logic y_plus,
  input  logic y_minus,
  output logic z_plus,
  output logic z_minus
);

  logic g_reg, ymn_reg, w_reg;
  logic h, g, t, w;
  logic g_prev, ymn_prev;

  // Level 1: x_plus + (1 - x_minus) + y_plus = 2h + g
  assign {h, g} = full_add(x_plus, ~x_minus, y_plus);

  // y_minus is kept inverted so the all-zero cleared state makes the first
  // level-2 add reduce to h alone, which places the leading carry at the
  // integer digit.
  assign g_prev   = clr ? 1'b0 : g_reg;
  assign ymn_prev = clr ? 1'b0 : ymn_reg;

  // Level 2: g(j) + (1 - y_minus(j)) + h(j+1) = 2t + w
  assign {t, w} = full_add(g_prev, ymn_prev, h);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_reg   <= 1'b0;
      ymn_reg <= 1'b0;
      w_reg   <= 1'b0;
      z_plus  <= 1'b0;
      z_minus <= 1'b0;
    end else if (adv) begin
      g_reg   <= g;
      ymn_reg <= ~y_minus;
      w_reg   <= w;
      z_plus  <= clr ? 1'b0 : w_reg;
      // result digit k = w(k) + t(k+1) - 1, so the minus rail carries ~t
      z_minus <= ~t;
    end
  end

endmodule

// File: rtl/online_adder_array.sv
// online_adder_array: N_CH-channel MSD-first online signed-digit adder with
// one shared frame controller. DIGITS input digits per operand per frame
// produce DIGITS+1 result digits (integer digit first), online delay 2.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_first input digit handshake and frame start
//   x_plus/x_minus, y_plus/y_minus  per-channel borrow-save operand digits
//   out_valid/out_first/out_last    result framing
//   z_plus/z_minus             per-channel borrow-save result digits
//   busy                       frame in progress (RUN or FLUSH)
//   proto_err                  only with OLA_PROTO_CHK_EN: sticky flag for
//                              in_first inside a frame or in_valid in FLUSH
//
// state | meaning
// IDLE  | waiting for in_first; digits without in_first are dropped
// RUN   | accepting digits 2..DIGITS
// FLUSH | two cycles pushing zero digits through the pipeline
module online_adder_array
  import ola_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DIGITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_first,
  input  logic [N_CH-1:0] x_plus,
  input  logic [N_CH-1:0] x_minus,
  input  logic [N_CH-1:0] y_plus,
  input  logic [N_CH-1:0] y_minus,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last,
  output logic [N_CH-1:0] z_plus,
  output logic [N_CH-1:0] z_minus,
  output logic            busy
`ifdef OLA_PROTO_CHK_EN
  ,
  output logic            proto_err
`endif
);

  localparam int CNT_W = $clog2(DIGITS + 3);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, idx;
  logic             start, adv, flush;
  logic [N_CH-1:0]  xp_d, xm_d, yp_d, ym_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_first) state_nxt = RUN;
      RUN:     if (in_valid && cnt == CNT_W'(DIGITS - 1)) state_nxt = FLUSH;
      FLUSH:   if (cnt == CNT_W'(DIGITS + 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx is the 1-based index of the input digit consumed by this advance;
  // flush digits are DIGITS+1 and DIGITS+2.
  always_comb begin
    in_ready = (state != FLUSH);
    busy     = (state != IDLE);
    flush    = (state == FLUSH);
    start    = (state == IDLE) && in_valid && in_first;
    adv      = start || ((state == RUN) && in_valid) || flush;
    idx      = start ? CNT_W'(1) : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (adv) cnt <= idx;
      out_valid <= adv && (idx >= CNT_W'(ONLINE_DELAY));
      out_first <= adv && (idx == CNT_W'(ONLINE_DELAY));
      out_last  <= adv && (idx == CNT_W'(DIGITS + ONLINE_DELAY));
    end
  end

  // Flush digits are forced to zero.
  assign xp_d = flush ? '0 : x_plus;
  assign xm_d = flush ? '0 : x_minus;
  assign yp_d = flush ? '0 : y_plus;
  assign ym_d = flush ? '0 : y_minus;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    ola_digit_slice u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .clr     (start),
      .x_plus  (xp_d[ch]),
      .x_minus (xm_d[ch]),
      .y_plus  (yp_d[ch]),
      .y_minus (ym_d[ch]),
      .z_plus  (z_plus[ch]),
      .z_minus (z_minus[ch])
    );
  end

`ifdef OLA_PROTO_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if (((state == RUN) && in_valid && in_first) ||
                 ((state == FLUSH) && in_valid)) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_online_adder_array.sv
// tb_online_adder_array: directed frames for online_adder_array (DIGITS=4).
// The stimulus pushes each channel's expected X+Y (scaled by 2^DIGITS) into
// a queue; a monitor rebuilds the value from the result digits and compares.
// Builds with or without OLA_PROTO_CHK_EN.
module tb_online_adder_array;
  import ola_pkg::*;

  localparam int N_CH   = 4;
  localparam int DIGITS = 4;
  localparam int NF     = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_first, in_ready;
  logic [N_CH-1:0] x_plus, x_minus, y_plus, y_minus;
  logic            out_valid, out_first, out_last, busy;
  logic [N_CH-1:0] z_plus, z_minus;
`ifdef OLA_PROTO_CHK_EN
  logic            proto_err;
`endif

  online_adder_array #(.N_CH(N_CH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .x_plus    (x_plus),
    .x_minus   (x_minus),
    .y_plus    (y_plus),
    .y_minus   (y_minus),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .z_plus    (z_plus),
    .z_minus   (z_minus),
    .busy      (busy)
`ifdef OLA_PROTO_CHK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  always #5 clk = ~clk;

  // Operand digits, MSD first. Frame 0: ch0 11/16 + 5/16 = 1.
  // Frame 1: every channel -15/16 + -15/16. Frame 2: mixed signs.
  int fx [NF][N_CH][DIGITS] = '{
    '{'{1, 0, 1, 1},     '{1, 1, 1, 1},     '{-1, 0, 1, 0},    '{0, 0, 0, 1}},
    '{'{-1, -1, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1}},
    '{'{1, 0, -1, 1},    '{0, 1, 1, 0},     '{1, 1, 1, 1},     '{-1, 1, -1, 1}}
  };
  int fy [NF][N_CH][DIGITS] = '{
    '{'{0, 1, 0, 1},     '{1, 1, 1, 1},     '{0, -1, 0, 1},    '{0, 0, 0, -1}},
    '{'{-1, -1, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1}},
    '{'{1, 1, 0, -1},    '{-1, 0, 0, 0},    '{1, 0, 0, 0},     '{0, 0, -1, -1}}
  };

  int sb[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int n_frames   = 0;
  int exp_frames = 0;
  int cyc        = 0;
  int acc_cyc    = 0;
  int first_cyc  = 0;
  int k          = 0;
  int acc [N_CH];
  int w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Exact X+Y of one channel scaled by 2^DIGITS.
  function automatic int frame_sum(input int f, input int ch);
    int s = 0;
    for (int i = 0; i < DIGITS; i++)
      s += (fx[f][ch][i] + fy[f][ch][i]) * (1 << (DIGITS - 1 - i));
    return s;
  endfunction

  task automatic drive_digit(input int f, input int i, input bit first, input bit z11);
    int dx, dy;
    in_valid = 1'b1;
    in_first = first;
    for (int ch = 0; ch < N_CH; ch++) begin
      dx = fx[f][ch][i];
      dy = fy[f][ch][i];
      x_plus[ch]  = (dx > 0) || (z11 && dx == 0);
      x_minus[ch] = (dx < 0) || (z11 && dx == 0);
      y_plus[ch]  = (dy > 0) || (z11 && dy == 0);
      y_minus[ch] = (dy < 0) || (z11 && dy == 0);
    end
  endtask

  task automatic wait_accept(output int waits);
    bit rs;
    waits = 0;
    forever begin
      rs = in_ready;
      @(posedge clk);
      #1;
      if (rs) break;
      waits++;
      if (waits > 20) begin
        check("accept_timeout", waits, 0);
        break;
      end
    end
  endtask

  task automatic send_frame(input int f, input bit gaps, input bit hold, input bit z11,
                            input int n_dig, input int first_at, output int first_wait);
    int wt, g;
    first_wait = 0;
    if (n_dig == DIGITS) exp_frames++;
    for (int ch = 0; ch < N_CH; ch++) sb.push_back(frame_sum(f, ch));
    for (int i = 0; i < n_dig; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 1);
        repeat (g) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
`ifdef OLA_PROTO_CHK_EN
      if (i == first_at) check("proto_err_before", int'(proto_err), 0);
`endif
      drive_digit(f, i, (i == 0) || (i == first_at), z11);
      wait_accept(wt);
      if (i == 0) begin
        first_wait = wt;
        acc_cyc    = cyc;
        check("busy_run", int'(busy), 1);
      end
`ifdef OLA_PROTO_CHK_EN
      if (i == first_at) check("proto_err_rise", int'(proto_err), 1);
`endif
    end
    in_first = 1'b0;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, sb.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_first"}, int'(out_first), 0);
    check({tag, "_out_last"},  int'(out_last), 0);
    check({tag, "_z_plus"},    int'(z_plus), 0);
    check({tag, "_z_minus"},   int'(z_minus), 0);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_in_ready"},  int'(in_ready), 1);
  endtask

  // Monitor: rebuilds each frame's value from result digits k=0..DIGITS.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
    end else if (out_valid) begin
      check("out_first", int'(out_first), (k == 0) ? 1 : 0);
      check("out_last",  int'(out_last), (k == DIGITS) ? 1 : 0);
      if (k == 0) first_cyc = cyc;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (k == 0) acc[ch] = 0;
        acc[ch] += (int'(z_plus[ch]) - int'(z_minus[ch])) * (1 << (DIGITS - k));
      end
      if (k == DIGITS) begin
        check("sb_has_entry", (sb.size() >= N_CH) ? 1 : 0, 1);
        if (sb.size() >= N_CH)
          for (int ch = 0; ch < N_CH; ch++)
            check($sformatf("value_ch%0d", ch), acc[ch], sb.pop_front());
        n_frames++;
        k = 0;
      end else begin
        k++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 100000", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    x_plus   = '0;
    x_minus  = '0;
    y_plus   = '0;
    y_minus  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("after_reset");

    // A digit without in_first in IDLE is dropped.
    x_plus   = '1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_plus   = '0;
    check("drop_busy", int'(busy), 0);
    check("drop_out_valid", int'(out_valid), 0);

    // Gapless frame; result digit 0 appears right after the digit-2 advance.
    send_frame(0, 1'b0, 1'b0, 1'b0, DIGITS, -1, w);
    wait_drain("drain_a");
    check("latency", first_cyc, acc_cyc + ONLINE_DELAY - 1);

    send_frame(1, 1'b0, 1'b0, 1'b0, DIGITS, -1, w);
    wait_drain("drain_b");

    // Zeros encoded as plus=minus=1.
    send_frame(2, 1'b0, 1'b0, 1'b1, DIGITS, -1, w);
    wait_drain("drain_c");

    // Same operands with random in_valid gaps.
    send_frame(2, 1'b1, 1'b0, 1'b0, DIGITS, -1, w);
    wait_drain("drain_c_gaps");

    // in_valid held across frame end: next in_first waits out both FLUSH cycles.
    send_frame(0, 1'b0, 1'b1, 1'b0, DIGITS, -1, w);
    send_frame(2, 1'b0, 1'b0, 1'b0, DIGITS, -1, w);
    check("flush_ready_low", w, 2);
    wait_drain("drain_b2b");

    // Reset after digit 2: partial frame discarded, outputs cleared at once.
    send_frame(1, 1'b0, 1'b0, 1'b0, 2, -1, w);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_quiet("mid_reset");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(0, 1'b0, 1'b0, 1'b0, DIGITS, -1, w);
    wait_drain("drain_after_reset");

`ifdef OLA_PROTO_CHK_EN
    check("proto_err_clean", int'(proto_err), 0);
    send_frame(0, 1'b0, 1'b0, 1'b0, DIGITS, 2, w);
    wait_drain("drain_proto");
    check("proto_err_sticky", int'(proto_err), 1);
    rst_n = 1'b0;
    #1;
    check("proto_err_reset", int'(proto_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("frames_seen", n_frames, exp_frames);
    check("monitor_idle", k, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
